// File: rtl/grf_pkg.sv
// Shared CPU constants and types for the general register file.
// The zero-register index and the commit rule live here so that every stage agrees on them.
package grf_pkg;

    localparam int REG_COUNT = 32;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;

    typedef logic [ADDR_W-1:0] regAddrT;
    typedef logic [DATA_W-1:0] wordT;

    localparam regAddrT ZERO_REG = '0;

    typedef struct packed {
        logic    vld;
        wordT    pc;
        regAddrT wa;
        wordT    wd;
    } traceT;

    // $0 is hardwired, so a write aimed at it never counts as a commit.
    function automatic logic isCommit(input logic wrEn, input regAddrT wa);
        return wrEn && (wa != ZERO_REG);
    endfunction

endpackage

// File: rtl/grf_if.sv
// Bundle of the Wb-stage write port, the two Id-stage read ports and the write trace.
interface grf_if;
    import grf_pkg::*;

    logic    ifWrGrf;
    regAddrT grfWa;
    wordT    grfWd;
    wordT    pcWb;
    regAddrT grfRa1;
    regAddrT grfRa2;
    wordT    grfRd1;
    wordT    grfRd2;
    logic    trVld;
    wordT    trPc;
    regAddrT trWa;
    wordT    trWd;

    modport master (
        output ifWrGrf, grfWa, grfWd, pcWb, grfRa1, grfRa2,
        input  grfRd1, grfRd2, trVld, trPc, trWa, trWd
    );

    modport slave (
        input  ifWrGrf, grfWa, grfWd, pcWb, grfRa1, grfRa2,
        output grfRd1, grfRd2, trVld, trPc, trWa, trWd
    );

endinterface

// File: rtl/grf_rd_port.sv
// One combinational read port: forces $0 to zero and forwards a same-cycle write when enabled.
module grf_rd_port
    import grf_pkg::*;
#(
    parameter int BYPASS_EN = 1
) (
    input  regAddrT ra,
    input  wordT    storeData,
    input  logic    wrCommit,
    input  regAddrT wa,
    input  wordT    wd,
    output wordT    rd
);

    // wrCommit already excludes $0, so the bypass can never leak data into $0.
    always_comb begin
        rd = storeData;
        if (ra == ZERO_REG) begin
            rd = '0;
        end else if ((BYPASS_EN == 1) && wrCommit && (wa == ra)) begin
            rd = wd;
        end
    end

endmodule

// File: rtl/grf.sv
// 32 x 32-bit general register file with two bypassed read ports and a registered write trace.
module grf
    import grf_pkg::*;
#(
    parameter int BYPASS_EN = 1,
    parameter int TRACE_EN  = 1
) (
    input logic  clk,
    input logic  reset,
    grf_if.slave bus
);

    logic wrCommit;
    wordT regView [REG_COUNT];

    assign wrCommit   = isCommit(bus.ifWrGrf, bus.grfWa);
    assign regView[0] = '0;

    // One flop bank per architectural register; $0 has no storage at all.
    genvar gi;
    generate
        for (gi = 1; gi < REG_COUNT; gi++) begin : g_reg
            wordT valueReg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    valueReg <= '0;
                end else if (wrCommit && (bus.grfWa == ADDR_W'(gi))) begin
                    valueReg <= bus.grfWd;
                end
            end

            assign regView[gi] = valueReg;
        end
    endgenerate

    grf_rd_port #(
        .BYPASS_EN (BYPASS_EN)
    ) u_rdPort1 (
        .ra        (bus.grfRa1),
        .storeData (regView[bus.grfRa1]),
        .wrCommit  (wrCommit),
        .wa        (bus.grfWa),
        .wd        (bus.grfWd),
        .rd        (bus.grfRd1)
    );

    grf_rd_port #(
        .BYPASS_EN (BYPASS_EN)
    ) u_rdPort2 (
        .ra        (bus.grfRa2),
        .storeData (regView[bus.grfRa2]),
        .wrCommit  (wrCommit),
        .wa        (bus.grfWa),
        .wd        (bus.grfWd),
        .rd        (bus.grfRd2)
    );

    generate
        if (TRACE_EN == 1) begin : g_trace
            traceT traceReg;

            // Payload fields hold their last value; only the valid bit drops back.
            always_ff @(posedge clk) begin
                if (reset) begin
                    traceReg <= '0;
                end else if (wrCommit) begin
                    traceReg.vld <= 1'b1;
                    traceReg.pc  <= bus.pcWb;
                    traceReg.wa  <= bus.grfWa;
                    traceReg.wd  <= bus.grfWd;
                end else begin
                    traceReg.vld <= 1'b0;
                end
            end

            assign bus.trVld = traceReg.vld;
            assign bus.trPc  = traceReg.pc;
            assign bus.trWa  = traceReg.wa;
            assign bus.trWd  = traceReg.wd;
        end else begin : g_noTrace
            assign bus.trVld = 1'b0;
            assign bus.trPc  = '0;
            assign bus.trWa  = '0;
            assign bus.trWd  = '0;
        end
    endgenerate

endmodule

// File: tb/tb_grf.sv
// Directed table-driven bench for grf: bypass and non-bypass instances plus a trace-disabled one.
module tb_grf;

    logic clk;
    logic rst;

    grf_if busByp ();
    grf_if busNoByp ();
    grf_if busNoTr ();

    grf #(.BYPASS_EN(1), .TRACE_EN(1)) dutByp   (.clk(clk), .reset(rst), .bus(busByp.slave));
    grf #(.BYPASS_EN(0), .TRACE_EN(1)) dutNoByp (.clk(clk), .reset(rst), .bus(busNoByp.slave));
    grf #(.BYPASS_EN(1), .TRACE_EN(0)) dutNoTr  (.clk(clk), .reset(rst), .bus(busNoTr.slave));

    assign busNoByp.ifWrGrf = busByp.ifWrGrf;
    assign busNoByp.grfWa   = busByp.grfWa;
    assign busNoByp.grfWd   = busByp.grfWd;
    assign busNoByp.pcWb    = busByp.pcWb;
    assign busNoByp.grfRa1  = busByp.grfRa1;
    assign busNoByp.grfRa2  = busByp.grfRa2;
    assign busNoTr.ifWrGrf  = busByp.ifWrGrf;
    assign busNoTr.grfWa    = busByp.grfWa;
    assign busNoTr.grfWd    = busByp.grfWd;
    assign busNoTr.pcWb     = busByp.pcWb;
    assign busNoTr.grfRa1   = busByp.grfRa1;
    assign busNoTr.grfRa2   = busByp.grfRa2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] n1;
        logic [31:0] n2;
        logic        chkTr;
        logic        eVld;
        logic [31:0] ePc;
        logic [4:0]  eWa;
        logic [31:0] eWd;
    } vecT;

    vecT vecs[$];
    int  testCount;
    int  failCount;

    function automatic vecT mk(
        input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic [31:0] pc, input logic [4:0] ra1, input logic [4:0] ra2,
        input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] n1,
        input logic [31:0] n2, input logic chkTr, input logic eVld,
        input logic [31:0] ePc, input logic [4:0] eWa, input logic [31:0] eWd);
        vecT v;
        v.rst = r;     v.we = we;     v.wa = wa;   v.wd = wd;   v.pc = pc;
        v.ra1 = ra1;   v.ra2 = ra2;   v.e1 = e1;   v.e2 = e2;   v.n1 = n1;
        v.n2 = n2;     v.chkTr = chkTr; v.eVld = eVld; v.ePc = ePc;
        v.eWa = eWa;   v.eWd = eWd;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s vec %0d: got %h, want %h", name, idx, act, exp);
        end
    endtask

    task automatic applyVec(input vecT v, input int idx);
        rst            = v.rst;
        busByp.ifWrGrf = v.we;
        busByp.grfWa   = v.wa;
        busByp.grfWd   = v.wd;
        busByp.pcWb    = v.pc;
        busByp.grfRa1  = v.ra1;
        busByp.grfRa2  = v.ra2;
        #1;
        chk("bypRd1", idx, busByp.grfRd1, v.e1);
        chk("bypRd2", idx, busByp.grfRd2, v.e2);
        chk("noBypRd1", idx, busNoByp.grfRd1, v.n1);
        chk("noBypRd2", idx, busNoByp.grfRd2, v.n2);
        if (v.chkTr) begin
            chk("trVld", idx, {31'b0, busByp.trVld}, {31'b0, v.eVld});
            chk("trPc", idx, busByp.trPc, v.ePc);
            chk("trWa", idx, {27'b0, busByp.trWa}, {27'b0, v.eWa});
            chk("trWd", idx, busByp.trWd, v.eWd);
            chk("noBypTrVld", idx, {31'b0, busNoByp.trVld}, {31'b0, v.eVld});
            chk("noBypTrWd", idx, busNoByp.trWd, v.eWd);
        end
        chk("noTrVld", idx, {31'b0, busNoTr.trVld}, 32'h0);
        chk("noTrWd", idx, busNoTr.trWd, 32'h0);
        $display("[TB] vec %0d rst=%0b we=%0b wa=%0d wd=%h ra=%0d/%0d rd=%h/%h nb=%h/%h tr=%0b/%h/%0d/%h",
                 idx, v.rst, v.we, v.wa, v.wd, v.ra1, v.ra2, busByp.grfRd1, busByp.grfRd2,
                 busNoByp.grfRd1, busNoByp.grfRd2, busByp.trVld, busByp.trPc,
                 busByp.trWa, busByp.trWd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        rst = 1'b1;
        busByp.ifWrGrf = 1'b0;
        busByp.grfWa = '0;
        busByp.grfWd = '0;
        busByp.pcWb = '0;
        busByp.grfRa1 = '0;
        busByp.grfRa2 = '0;

        // Reset, then sweep all 32 addresses expecting zero.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 16; i++) begin
            vecs.push_back(mk(0, 0, 0, 0, 0, 5'(2 * i), 5'(2 * i + 1),
                              0, 0, 0, 0, 1, 0, 0, 0, 0));
        end
        // $5 write and trace, then same-cycle bypass on $7.
        vecs.push_back(mk(0, 1, 5, 32'h12345678, 32'h3000, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 5, 0, 32'h12345678, 0, 32'h12345678, 0,
                          1, 1, 32'h3000, 5, 32'h12345678));
        vecs.push_back(mk(0, 0, 0, 0, 0, 5, 5, 32'h12345678, 32'h12345678, 32'h12345678,
                          32'h12345678, 1, 0, 32'h3000, 5, 32'h12345678));
        vecs.push_back(mk(0, 1, 7, 32'hDEADBEEF, 32'h3004, 7, 7, 32'hDEADBEEF, 32'hDEADBEEF,
                          0, 0, 1, 0, 32'h3000, 5, 32'h12345678));
        vecs.push_back(mk(0, 0, 0, 0, 0, 7, 5, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF,
                          32'h12345678, 1, 1, 32'h3004, 7, 32'hDEADBEEF));
        // Write to $0 is discarded: no bypass, no pulse.
        vecs.push_back(mk(0, 1, 0, 32'hFFFFFFFF, 32'h3008, 0, 0, 0, 0, 0, 0,
                          1, 0, 32'h3004, 7, 32'hDEADBEEF));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 7, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF,
                          1, 0, 32'h3004, 7, 32'hDEADBEEF));
        // Reset beats a simultaneous write; bypass still visible during reset.
        vecs.push_back(mk(1, 1, 3, 32'hA, 32'h300C, 3, 7, 32'hA, 32'hDEADBEEF, 0, 32'hDEADBEEF,
                          1, 0, 32'h3004, 7, 32'hDEADBEEF));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        // Back-to-back writes $1=1, $2=2, $1=3.
        vecs.push_back(mk(0, 1, 1, 1, 32'h3010, 1, 2, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2, 2, 32'h3014, 1, 2, 1, 2, 1, 0, 1, 1, 32'h3010, 1, 1));
        vecs.push_back(mk(0, 1, 1, 3, 32'h3018, 1, 2, 3, 2, 1, 2, 1, 1, 32'h3014, 2, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2, 3, 2, 3, 2, 1, 1, 32'h3018, 1, 3));
        // Reset in the cycle after a write kills the pulse at that edge.
        vecs.push_back(mk(0, 1, 4, 32'h55, 32'h301C, 4, 4, 32'h55, 32'h55, 0, 0,
                          1, 0, 32'h3018, 1, 3));
        vecs.push_back(mk(1, 0, 0, 0, 0, 4, 0, 32'h55, 0, 32'h55, 0, 1, 1, 32'h301C, 4, 32'h55));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        // Same address, same data twice still gives two pulses.
        vecs.push_back(mk(0, 1, 6, 32'h77, 32'h3020, 6, 6, 32'h77, 32'h77, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 6, 32'h77, 32'h3024, 9, 9, 0, 0, 0, 0, 1, 1, 32'h3020, 6, 32'h77));
        vecs.push_back(mk(0, 0, 0, 0, 0, 6, 6, 32'h77, 32'h77, 32'h77, 32'h77,
                          1, 1, 32'h3024, 6, 32'h77));

        foreach (vecs[i]) begin
            applyVec(vecs[i], i);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
